control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired Moore control sequencer that fetches, decodes and steps each instruction through T-states. It drives the register-select controls (Gra/Grb/Grc/Rin/Rout/BAout) consumed by the select-and-encode stage, plus all bus, ALU and memory strobes. It sits directly upstream of that stage and the datapath, and paces memory through a ready handshake.

## Interface
- No parameters; opcode field is IR[31:27], fixed.
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high; forces state IDLE
- IR  in  32  current instruction register contents
- con_ff  in  1  branch condition flip-flop result
- mem_ready  in  1  memory completes the Read/Write held this cycle
- stop  in  1  level; halt at next instruction boundary
- PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin, MDRout, IRin, Cout, CONin  out  1 each  datapath strobes
- Read, Write  out  1 each  memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select controls
- alu_op  out  5  ALU operation code
- run  out  1  high unless halted

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT. Outputs are decoded from state and IR[31:27] only. Undriven outputs are 0.
- IDLE: all outputs 0, run=1. Next state is T0 (or HALT if stop=1).
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. Held while mem_ready=0.
- T2: MDRout, IRin. Next state is T3.
- Reg-reg ALU (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- Immediate ALU (addi 01011, andi 01100, ori 01101):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- ldi 00001:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=00011.
  - T5: Zlowout, Gra, Rin. Then T0.
- ld 00000:
  - T3–T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Held while mem_ready=0.
  - T7: MDRout, Gra, Rin. Then T0.
- st 00010:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write. Held while mem_ready=0. Then T0.
- br 10010:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, alu_op=00011.
  - T6: Zlowout, plus PCin iff con_ff=1. Then T0.
- nop 11001, and every unlisted opcode: T3 asserts nothing, then T0.
- halt 11010: T3 goes to HALT.
- HALT: all outputs 0, run=0. Left only by reset.
- stop: sampled only on the clock edge leaving the final T-state of an instruction (or IDLE). If stop=1, the next state is HALT instead of T0.
- alu_op=00000 in every state not listed above.

## Timing
- One state per clock. The exceptions are T1, ld-T6 and st-T7, which stall until the first edge with mem_ready=1.
- During a stall, all strobes of that state stay asserted and unchanged.
- Instruction length, assuming zero wait states:
  - reg-reg / immediate / ldi: 6 cycles
  - ld / st: 8 cycles
  - br: 7 cycles
  - nop: 4 cycles
- Each memory wait cycle adds exactly 1 cycle.
- reset asserted at any time, including mid-stall or mid-instruction:
  - All outputs go to 0 immediately; run=1.
  - State is IDLE while reset=1.
  - The first clock after deassertion enters T0.
- mem_ready outside a memory state is ignored.
- stop and halt opcode together: HALT is entered once.

## Test plan
- Reset, then mem_ready=1 constant, IR=0x18110000 (add R3,R2,R2) → T0 strobes on cycle 1 after reset. At T4: Grc, Rout, Zin, alu_op=00011. At T5: Gra, Rin. T0 again at cycle 7.
- ld, IR=0x00800005, mem_ready low 3 cycles in T6 → Read and MDRin held 4 cycles. Gra and Rin asserted in the cycle after mem_ready rises.
- br with con_ff=0, then con_ff=1 → T6 has Zlowout only in the first case, Zlowout+PCin in the second. Both take 7 cycles.
- halt opcode 11010 → HALT after T3; run=0 and all strobes 0 for 20 cycles. After reset pulse, run=1 and T0 follows IDLE.
- stop raised during T4 of an addi → addi completes T5 with Gra and Rin. Next state is HALT, not T0.
- reset asserted mid-stall in T1 → all outputs 0 in the same cycle; IDLE, then T0 after deassertion.

Source files
------------

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Hardwired Moore control sequencer. Fetches an instruction (T0-T2), then
// steps it through the execute T-states (T3-T7) that its opcode needs.
// It drives every datapath, ALU and memory strobe, plus the register-select
// controls consumed by the select-and-encode stage.
//
// Ports
//   clock      rising-edge system clock
//   reset      asynchronous, active-high; forces IDLE
//   IR         instruction register; the opcode is IR[31:27]
//   con_ff     branch condition result (used in br T6)
//   mem_ready  memory finishes the Read/Write held this cycle
//   stop       level; halt at the next instruction boundary
//   PCout..CONin, Read, Write, Gra..BAout   control strobes (active high)
//   alu_op     ALU operation code
//   run        high unless the sequencer is in HALT
//   state_dbg  current state encoding, for observation only
//
// Handshake: memory states (T1, ld-T6, st-T7) hold their Read/Write strobe
// and remain in place on every edge where mem_ready=0; the state is left on
// the first edge where mem_ready=1. mem_ready is ignored in all other states.
//
// Outputs are combinational in the current state and IR. IR is loaded by
// IRin on the same edge that enters T3, so decoding from a registered copy
// of the old IR would select the wrong T3 strobes.
// ---------------------------------------------------------------------------
module control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Yin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Cout,
    output logic        CONin,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t     state;
    state_t     next_state;
    state_t     boundary;
    logic [4:0] opcode;
    logic       is_rr, is_imm, is_ldi, is_ld, is_st, is_br, is_halt;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign state_dbg = state;

    // Opcode classes. add..or form one contiguous range, addi..ori another.
    assign is_rr   = (opcode >= OP_ADD) && (opcode <= OP_OR);
    assign is_imm  = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_halt = (opcode == OP_HALT);

    // Where to go after the last T-state of an instruction.
    assign boundary = stop ? HALT : T0;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = boundary;
            T0:   next_state = T1;
            T1:   next_state = mem_ready ? T2 : T1;
            T2:   next_state = T3;
            T3: begin
                if (is_halt)
                    next_state = HALT;
                else if (is_rr || is_imm || is_ldi || is_ld || is_st || is_br)
                    next_state = T4;
                else
                    next_state = boundary;
            end
            T4:   next_state = T5;
            T5:   next_state = (is_ld || is_st || is_br) ? T6 : boundary;
            T6: begin
                if (is_ld)
                    next_state = mem_ready ? T7 : T6;
                else if (is_st)
                    next_state = T7;
                else
                    next_state = boundary;
            end
            T7: begin
                if (is_st)
                    next_state = mem_ready ? boundary : T7;
                else
                    next_state = boundary;
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Moore strobe decode. Anything not assigned for a state stays 0.
    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        PCin    = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Yin     = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Cout    = 1'b0;
        CONin   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        alu_op  = 5'b00000;
        run     = (state != HALT);
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_rr || is_imm) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    // Base register, or zero when it is R0, into Y.
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (is_br) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end
            end
            T4: begin
                if (is_rr) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = opcode;
                end else if (is_imm) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = opcode;
                end else if (is_ldi || is_ld || is_st) begin
                    // Effective address = base + constant, computed with add.
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = OP_ADD;
                end else if (is_br) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
            end
            T5: begin
                if (is_rr || is_imm || is_ldi) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end else if (is_br) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = OP_ADD;
                end
            end
            T6: begin
                if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_st) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_br) begin
                    // Branch target is always on the bus; PC takes it only
                    // when the condition held.
                    Zlowout = 1'b1;
                    PCin    = con_ff;
                end
            end
            T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Per-cycle vector table: each record holds the inputs applied in one clock
// cycle and the strobes/state expected during that same cycle (before the
// edge that closes it). A hand-written sequence then measures the length of
// an ld with memory wait states.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    // Strobe bit positions in the packed 20-bit strobe word.
    localparam logic [19:0] B_PCOUT   = 20'h80000;
    localparam logic [19:0] B_MARIN   = 20'h40000;
    localparam logic [19:0] B_INCPC   = 20'h20000;
    localparam logic [19:0] B_PCIN    = 20'h10000;
    localparam logic [19:0] B_ZIN     = 20'h08000;
    localparam logic [19:0] B_ZLOWOUT = 20'h04000;
    localparam logic [19:0] B_YIN     = 20'h02000;
    localparam logic [19:0] B_MDRIN   = 20'h01000;
    localparam logic [19:0] B_MDROUT  = 20'h00800;
    localparam logic [19:0] B_IRIN    = 20'h00400;
    localparam logic [19:0] B_COUT    = 20'h00200;
    localparam logic [19:0] B_CONIN   = 20'h00100;
    localparam logic [19:0] B_READ    = 20'h00080;
    localparam logic [19:0] B_WRITE   = 20'h00040;
    localparam logic [19:0] B_GRA     = 20'h00020;
    localparam logic [19:0] B_GRB     = 20'h00010;
    localparam logic [19:0] B_GRC     = 20'h00008;
    localparam logic [19:0] B_RIN     = 20'h00004;
    localparam logic [19:0] B_ROUT    = 20'h00002;
    localparam logic [19:0] B_BAOUT   = 20'h00001;

    localparam logic [19:0] X_NONE = 20'h0;
    localparam logic [19:0] X_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [19:0] X_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [19:0] X_T2   = B_MDROUT | B_IRIN;
    localparam logic [19:0] X_RR3  = B_GRB | B_ROUT | B_YIN;
    localparam logic [19:0] X_RR4  = B_GRC | B_ROUT | B_ZIN;
    localparam logic [19:0] X_WB   = B_ZLOWOUT | B_GRA | B_RIN;
    localparam logic [19:0] X_IM4  = B_COUT | B_ZIN;
    localparam logic [19:0] X_LD3  = B_GRB | B_BAOUT | B_YIN;
    localparam logic [19:0] X_LD5  = B_ZLOWOUT | B_MARIN;
    localparam logic [19:0] X_LD6  = B_READ | B_MDRIN;
    localparam logic [19:0] X_LD7  = B_MDROUT | B_GRA | B_RIN;
    localparam logic [19:0] X_ST6  = B_GRA | B_ROUT | B_MDRIN;
    localparam logic [19:0] X_ST7  = B_WRITE;
    localparam logic [19:0] X_BR3  = B_GRA | B_ROUT | B_CONIN;
    localparam logic [19:0] X_BR4  = B_PCOUT | B_YIN;
    localparam logic [19:0] X_BR5  = B_COUT | B_ZIN;
    localparam logic [19:0] X_BR6  = B_ZLOWOUT;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [31:0] I_ADD  = 32'h18110000;
    localparam logic [31:0] I_LD   = 32'h00800005;
    localparam logic [31:0] I_ST   = 32'h10800007;
    localparam logic [31:0] I_BR   = 32'h90000004;
    localparam logic [31:0] I_NOP  = 32'hC8000000;
    localparam logic [31:0] I_UNK  = 32'hF8000000;
    localparam logic [31:0] I_OR   = 32'h50110000;
    localparam logic [31:0] I_ADDI = 32'h58100003;
    localparam logic [31:0] I_HALT = 32'hD0000000;

    typedef struct {
        logic        rst;
        logic [31:0] ir;
        logic        mr;
        logic        stp;
        logic        cf;
        logic [19:0] exp_sig;
        logic [4:0]  exp_alu;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    // clock/reset block
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        con_ff = 1'b0;
    logic        mem_ready = 1'b1;
    logic        stop = 1'b0;

    always #5 clock = ~clock;

    logic PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin, MDRout, IRin;
    logic Cout, CONin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
    logic [4:0]  alu_op;
    logic [3:0]  state_dbg;
    logic [19:0] act_sig;

    assign act_sig = {PCout, MARin, IncPC, PCin, Zin, Zlowout, Yin, MDRin,
                      MDRout, IRin, Cout, CONin, Read, Write, Gra, Grb, Grc,
                      Rin, Rout, BAout};

    control_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .IR        (IR),
        .con_ff    (con_ff),
        .mem_ready (mem_ready),
        .stop      (stop),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .PCin      (PCin),
        .Zin       (Zin),
        .Zlowout   (Zlowout),
        .Yin       (Yin),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Cout      (Cout),
        .CONin     (CONin),
        .Read      (Read),
        .Write     (Write),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .Rin       (Rin),
        .Rout      (Rout),
        .BAout     (BAout),
        .alu_op    (alu_op),
        .run       (run),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard compare
    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // table builders
    task automatic v(input logic r, input logic [31:0] ir, input logic mr,
                     input logic stp, input logic cf, input logic [19:0] sig,
                     input logic [4:0] alu, input logic [3:0] st);
        vec_t e;
        e.rst = r; e.ir = ir; e.mr = mr; e.stp = stp; e.cf = cf;
        e.exp_sig = sig; e.exp_alu = alu; e.exp_st = st;
        vecs.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] ir);
        v(0, ir, 1, 0, 0, X_T0, 5'd0, S_T0);
        v(0, ir, 1, 0, 0, X_T1, 5'd0, S_T1);
        v(0, ir, 1, 0, 0, X_T2, 5'd0, S_T2);
    endtask

    task automatic halted(input int n, input logic [31:0] ir);
        for (int i = 0; i < n; i++)
            v(0, ir, i[0], 0, i[1], X_NONE, 5'd0, S_HALT);
    endtask

    task automatic build_table();
        // reset and release: IDLE until the first edge after release
        v(1, I_ADD, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(1, I_ADD, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_ADD, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        // add R3,R2,R2
        fetch(I_ADD);
        v(0, I_ADD, 1, 0, 0, X_RR3, 5'd0,     S_T3);
        v(0, I_ADD, 1, 0, 0, X_RR4, 5'b00011, S_T4);
        v(0, I_ADD, 1, 0, 0, X_WB,  5'd0,     S_T5);
        // ld with 2 wait cycles in T1 and 3 in T6
        v(0, I_LD, 1, 0, 0, X_T0, 5'd0, S_T0);
        v(0, I_LD, 0, 0, 0, X_T1, 5'd0, S_T1);
        v(0, I_LD, 0, 0, 0, X_T1, 5'd0, S_T1);
        v(0, I_LD, 1, 0, 0, X_T1, 5'd0, S_T1);
        v(0, I_LD, 1, 0, 0, X_T2, 5'd0, S_T2);
        v(0, I_LD, 1, 0, 0, X_LD3, 5'd0,     S_T3);
        v(0, I_LD, 1, 0, 0, X_IM4, 5'b00011, S_T4);
        v(0, I_LD, 1, 0, 0, X_LD5, 5'd0,     S_T5);
        v(0, I_LD, 0, 0, 0, X_LD6, 5'd0,     S_T6);
        v(0, I_LD, 0, 0, 0, X_LD6, 5'd0,     S_T6);
        v(0, I_LD, 0, 0, 0, X_LD6, 5'd0,     S_T6);
        v(0, I_LD, 1, 0, 0, X_LD6, 5'd0,     S_T6);
        v(0, I_LD, 1, 0, 0, X_LD7, 5'd0,     S_T7);
        // st: mem_ready low in T6 is ignored, one wait cycle in T7
        fetch(I_ST);
        v(0, I_ST, 1, 0, 0, X_LD3, 5'd0,     S_T3);
        v(0, I_ST, 1, 0, 0, X_IM4, 5'b00011, S_T4);
        v(0, I_ST, 1, 0, 0, X_LD5, 5'd0,     S_T5);
        v(0, I_ST, 0, 0, 0, X_ST6, 5'd0,     S_T6);
        v(0, I_ST, 0, 0, 0, X_ST7, 5'd0,     S_T7);
        v(0, I_ST, 1, 0, 0, X_ST7, 5'd0,     S_T7);
        // br not taken
        fetch(I_BR);
        v(0, I_BR, 1, 0, 0, X_BR3, 5'd0,     S_T3);
        v(0, I_BR, 0, 0, 0, X_BR4, 5'd0,     S_T4);
        v(0, I_BR, 1, 0, 0, X_BR5, 5'b00011, S_T5);
        v(0, I_BR, 1, 0, 0, X_BR6, 5'd0,     S_T6);
        // br taken
        fetch(I_BR);
        v(0, I_BR, 1, 0, 1, X_BR3, 5'd0,     S_T3);
        v(0, I_BR, 1, 0, 1, X_BR4, 5'd0,     S_T4);
        v(0, I_BR, 1, 0, 1, X_BR5, 5'b00011, S_T5);
        v(0, I_BR, 1, 0, 1, X_BR6 | B_PCIN, 5'd0, S_T6);
        // nop and an unlisted opcode end after T3
        fetch(I_NOP);
        v(0, I_NOP, 1, 0, 0, X_NONE, 5'd0, S_T3);
        fetch(I_UNK);
        v(0, I_UNK, 1, 0, 0, X_NONE, 5'd0, S_T3);
        // or R?: alu_op carries the opcode
        fetch(I_OR);
        v(0, I_OR, 1, 0, 0, X_RR3, 5'd0,     S_T3);
        v(0, I_OR, 1, 0, 0, X_RR4, 5'b01010, S_T4);
        v(0, I_OR, 1, 0, 0, X_WB,  5'd0,     S_T5);
        // addi with stop raised in T4: completes, then HALT
        fetch(I_ADDI);
        v(0, I_ADDI, 1, 0, 0, X_RR3, 5'd0,     S_T3);
        v(0, I_ADDI, 1, 1, 0, X_IM4, 5'b01011, S_T4);
        v(0, I_ADDI, 1, 1, 0, X_WB,  5'd0,     S_T5);
        halted(3, I_ADDI);
        // reset pulse leaves HALT
        v(1, I_HALT, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_HALT, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        // halt opcode
        fetch(I_HALT);
        v(0, I_HALT, 1, 0, 0, X_NONE, 5'd0, S_T3);
        halted(20, I_HALT);
        // reset during a T1 stall
        v(1, I_ADD, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_ADD, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_ADD, 0, 0, 0, X_T0,   5'd0, S_T0);
        v(0, I_ADD, 0, 0, 0, X_T1,   5'd0, S_T1);
        v(1, I_ADD, 0, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_ADD, 0, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_ADD, 1, 0, 0, X_T0,   5'd0, S_T0);
        v(0, I_ADD, 1, 0, 0, X_T1,   5'd0, S_T1);
        v(0, I_ADD, 1, 0, 0, X_T2,   5'd0, S_T2);
        // stop sampled in IDLE
        v(1, I_ADD, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_ADD, 1, 1, 0, X_NONE, 5'd0, S_IDLE);
        halted(2, I_ADD);
        // stop together with the halt opcode
        v(1, I_HALT, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        v(0, I_HALT, 1, 0, 0, X_NONE, 5'd0, S_IDLE);
        fetch(I_HALT);
        v(0, I_HALT, 1, 1, 0, X_NONE, 5'd0, S_T3);
        halted(2, I_HALT);
    endtask

    initial begin
        int cyc;
        int w1;
        int w6;
        build_table();
        @(posedge clock);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            IR        = vecs[i].ir;
            mem_ready = vecs[i].mr;
            stop      = vecs[i].stp;
            con_ff    = vecs[i].cf;
            #1;
            check("strobes", i, {12'h0, act_sig}, {12'h0, vecs[i].exp_sig});
            check("alu_op",  i, {27'h0, alu_op}, {27'h0, vecs[i].exp_alu});
            check("state",   i, {28'h0, state_dbg}, {28'h0, vecs[i].exp_st});
            check("run",     i, {31'h0, run},
                  {31'h0, (vecs[i].exp_st == S_HALT) ? 1'b0 : 1'b1});
            @(posedge clock);
            #1;
        end

        // ld with 2 wait cycles in T1 and 1 in T6: 8 + 3 = 11 cycles T0..T0
        reset = 1'b1; stop = 1'b0; con_ff = 1'b0; mem_ready = 1'b1; IR = I_LD;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("ld_start_t0", -1, {28'h0, state_dbg}, {28'h0, S_T0});
        cyc = 0;
        w1  = 0;
        w6  = 0;
        do begin
            mem_ready = 1'b1;
            if (state_dbg == S_T1 && w1 < 2) begin
                mem_ready = 1'b0;
                w1++;
            end
            if (state_dbg == S_T6 && w6 < 1) begin
                mem_ready = 1'b0;
                w6++;
            end
            @(posedge clock);
            #1;
            cyc++;
        end while (state_dbg != S_T0 && cyc < 50);
        check("ld_wait_length", -1, cyc, 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
